jtag_bus_bridge: RTL and testbench

Virtual-JTAG-to-register-bus controller. Decodes the VJTAG instruction register and virtual-state strobes, shifts address and data through one shift register, and sequences single-beat read/write transactions on a simple req/ack bus. It sits between the VJTAG adapter and the design's register bank, replacing per-register JTAG instructions with one addressed access path.

---
 rtl/jtag_bus_bridge.sv | 166 ++++++++++++++++
 tb/tb_jtag_bus_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_bus_bridge.sv
// rtl/jtag_bus_bridge.sv - virtual-JTAG to req/ack register bus bridge
// One shared DR shift register carries address, write data, read data and status.
module jtag_bus_bridge #(
  parameter int          ADDR_W        = 8,
  parameter int          DATA_W        = 8,
  parameter int          TIMEOUT       = 255,
  parameter int          AUTO_INC      = 1,
  parameter logic [7:0]  JTAG_SET_ADDR = 8'h10,
  parameter logic [7:0]  JTAG_WRITE    = 8'h11,
  parameter logic [7:0]  JTAG_READ     = 8'h12,
  parameter logic [7:0]  JTAG_STATUS   = 8'h13
) (
  input  logic              tck,
  input  logic              reset_n,
  input  logic [7:0]        ir_in,
  input  logic              tdi,
  input  logic              vs_cdr,
  input  logic              vs_sdr,
  input  logic              vs_udr,
  output logic              tdo,
  output logic [7:0]        ir_out,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_sr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic                r_timeout_err;
  logic                r_overrun_err;

  logic                w_is_set;
  logic                w_is_write;
  logic                w_is_read;
  logic                w_is_status;
  logic                w_known;
  logic                w_busy;
  logic                w_start;
  logic                w_success;
  logic                w_abort;
  logic                w_overrun;
  logic [DATA_W-1:0]   w_status;

  assign w_is_set    = (ir_in == JTAG_SET_ADDR);
  assign w_is_write  = (ir_in == JTAG_WRITE);
  assign w_is_read   = (ir_in == JTAG_READ);
  assign w_is_status = (ir_in == JTAG_STATUS);
  assign w_known     = w_is_set | w_is_write | w_is_read | w_is_status;
  assign w_busy      = (r_state == S_REQ);
  assign w_status    = {{(DATA_W-3){1'b0}}, r_timeout_err, r_overrun_err, w_busy};

  assign tdo       = (w_is_read | w_is_status) ? r_sr[0] : 1'b0;
  assign ir_out    = {5'b0, r_timeout_err, r_overrun_err, w_busy};
  assign bus_req   = w_busy;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

  // Timeout fires on the TIMEOUT-th request cycle unless that same cycle carries an ack.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_success   = 1'b0;
    w_abort     = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (vs_udr && (w_is_write || w_is_read)) begin
          w_start     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_ack) begin
          w_success   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
        if (vs_udr && (w_is_write || w_is_read || w_is_set)) begin
          w_overrun = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge tck or negedge reset_n) begin
    if (!reset_n) begin
      r_sr          <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_cnt         <= '0;
      r_we          <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_known) begin
        if (vs_cdr && w_is_read) begin
          r_sr <= r_rdata;
        end else if (vs_cdr && w_is_status) begin
          r_sr <= w_status;
        end else if (vs_sdr) begin
          r_sr <= {tdi, r_sr[DATA_W-1:1]};
        end
      end

      if (w_start) begin
        r_we  <= w_is_write;
        r_cnt <= '0;
        if (w_is_write) begin
          r_wdata <= r_sr;
        end
      end else if (w_busy && (w_state_nxt == S_REQ)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_is_set && vs_udr && !w_busy) begin
        r_addr <= r_sr[ADDR_W-1:0];
      end else if (w_success && (AUTO_INC != 0)) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

      if (w_success && !r_we) begin
        r_rdata <= bus_rdata;
      end

      // A newly raised error beats a STATUS clear on the same edge.
      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end else if (w_is_status && vs_udr) begin
        r_timeout_err <= 1'b0;
      end

      if (w_overrun) begin
        r_overrun_err <= 1'b1;
      end else if (w_is_status && vs_udr) begin
        r_overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtag_bus_bridge.sv
// tb/tb_jtag_bus_bridge.sv - self-checking bench for jtag_bus_bridge
module tb_jtag_bus_bridge;

  localparam logic [7:0] IR_SET    = 8'h10;
  localparam logic [7:0] IR_WRITE  = 8'h11;
  localparam logic [7:0] IR_READ   = 8'h12;
  localparam logic [7:0] IR_STATUS = 8'h13;

  logic       tck;
  logic       reset_n;
  logic [7:0] ir_in;
  logic       tdi;
  logic       vs_cdr;
  logic       vs_sdr;
  logic       vs_udr;
  logic       tdo;
  logic [7:0] ir_out;
  logic       bus_req;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_ack;

  jtag_bus_bridge #(
    .ADDR_W(8), .DATA_W(8), .TIMEOUT(4), .AUTO_INC(1)
  ) dut (
    .tck(tck), .reset_n(reset_n), .ir_in(ir_in), .tdi(tdi),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tdo(tdo),
    .ir_out(ir_out), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  typedef struct {
    logic       set_addr;
    logic [7:0] addr;
    logic       we;
    logic [7:0] data;
    logic [7:0] rdata;
    int         ack_delay;
    logic [7:0] exp_bus_addr;
    logic [7:0] exp_dout;
    logic [7:0] exp_next_addr;
  } vec_t;

  txn_t       exp_q[$];
  txn_t       t_mon;
  vec_t       vecs[6];
  int         n_checks;
  int         n_fail;
  int         resp_delay;
  logic [7:0] resp_rdata;
  int         req_cycles;
  int         last_req_len;
  int         total_reqs;
  logic [7:0] dout;
  logic [7:0] dummy;
  int         reqs_before;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus responder and scoreboard: expected transactions are popped on the first req cycle.
  always @(negedge tck) begin
    if (bus_req) begin
      req_cycles = req_cycles + 1;
      if (req_cycles == 1) begin
        total_reqs++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got addr 0x%0h expected no request", bus_addr);
        end else begin
          t_mon = exp_q.pop_front();
          check("bus_we", int'(bus_we), int'(t_mon.we));
          check("bus_addr", int'(bus_addr), int'(t_mon.addr));
          if (t_mon.we) check("bus_wdata", int'(bus_wdata), int'(t_mon.wdata));
        end
      end
      bus_ack   = (resp_delay != 0) && (req_cycles == resp_delay);
      bus_rdata = resp_rdata;
    end else begin
      if (req_cycles != 0) last_req_len = req_cycles;
      req_cycles = 0;
      bus_ack    = 1'b0;
    end
  end

  task automatic scan(input logic [7:0] ir, input logic [7:0] din, output logic [7:0] dout_o);
    @(negedge tck);
    ir_in  = ir;
    vs_cdr = 1'b1;
    @(negedge tck);
    vs_cdr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vs_sdr    = 1'b1;
      tdi       = din[i];
      dout_o[i] = tdo;
      @(negedge tck);
    end
    vs_sdr = 1'b0;
    vs_udr = 1'b1;
    @(negedge tck);
    vs_udr = 1'b0;
  endtask

  task automatic udr_pulse(input logic [7:0] ir);
    ir_in  = ir;
    vs_udr = 1'b1;
    @(negedge tck);
    vs_udr = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && bus_req; i++) @(negedge tck);
    if (bus_req) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: got bus_req 1 expected 0 within 20 cycles");
    end
    @(negedge tck);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    resp_delay = 1; resp_rdata = 8'h00;
    req_cycles = 0; last_req_len = 0; total_reqs = 0;
    reset_n = 1'b0; ir_in = 8'h00; tdi = 1'b0;
    vs_cdr = 1'b0; vs_sdr = 1'b0; vs_udr = 1'b0;
    bus_rdata = 8'h00; bus_ack = 1'b0;

    //          set   addr   we    data   rdata  dly bus_a  dout   next
    vecs[0] = '{1'b1, 8'h05, 1'b1, 8'hA5, 8'h00, 3, 8'h05, 8'h00, 8'h06};
    vecs[1] = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h3C, 1, 8'hFF, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h5A, 2, 8'h00, 8'h3C, 8'h01};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 8'h77, 8'h00, 1, 8'h01, 8'h00, 8'h02};
    vecs[4] = '{1'b1, 8'h80, 1'b0, 8'h00, 8'hC3, 4, 8'h80, 8'h5A, 8'h81};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h11, 2, 8'h81, 8'hC3, 8'h82};

    repeat (3) @(negedge tck);
    check("rst_bus_req", int'(bus_req), 0);
    check("rst_tdo", int'(tdo), 0);
    check("rst_ir_out", int'(ir_out), 0);
    check("rst_bus_addr", int'(bus_addr), 0);
    check("rst_bus_we", int'(bus_we), 0);
    check("rst_bus_wdata", int'(bus_wdata), 0);
    reset_n = 1'b1;
    @(negedge tck);

    for (int k = 0; k < 6; k++) begin
      if (vecs[k].set_addr) scan(IR_SET, vecs[k].addr, dummy);
      resp_delay = vecs[k].ack_delay;
      resp_rdata = vecs[k].rdata;
      exp_q.push_back('{we: vecs[k].we, addr: vecs[k].exp_bus_addr, wdata: vecs[k].data});
      scan(vecs[k].we ? IR_WRITE : IR_READ, vecs[k].data, dout);
      check($sformatf("v%0d_dout", k), int'(dout), int'(vecs[k].exp_dout));
      wait_idle();
      check($sformatf("v%0d_req_len", k), last_req_len, vecs[k].ack_delay);
      check($sformatf("v%0d_next_addr", k), int'(bus_addr), int'(vecs[k].exp_next_addr));
    end

    // Overrun: WRITE and SET_ADDR updates while busy, ack on the TIMEOUT-th cycle.
    resp_delay  = 4;
    reqs_before = total_reqs;
    exp_q.push_back('{we: 1'b1, addr: 8'h82, wdata: 8'h3E});
    scan(IR_WRITE, 8'h3E, dummy);
    udr_pulse(IR_WRITE);
    udr_pulse(IR_SET);
    wait_idle();
    repeat (3) @(negedge tck);
    check("ovr_req_len", last_req_len, 4);
    check("ovr_req_count", total_reqs - reqs_before, 1);
    check("ovr_addr", int'(bus_addr), 8'h83);
    check("ovr_ir_out", int'(ir_out), 8'h02);
    scan(IR_STATUS, 8'h00, dout);
    check("ovr_status", int'(dout), 8'h02);

    // Timeout: no ack at all.
    resp_delay = 0;
    exp_q.push_back('{we: 1'b1, addr: 8'h83, wdata: 8'h99});
    scan(IR_WRITE, 8'h99, dummy);
    wait_idle();
    check("to_req_len", last_req_len, 4);
    check("to_addr", int'(bus_addr), 8'h83);
    check("to_ir_out", int'(ir_out), 8'h04);
    scan(IR_STATUS, 8'h00, dout);
    check("to_status1", int'(dout), 8'h04);
    scan(IR_STATUS, 8'h00, dout);
    check("to_status2", int'(dout), 8'h00);

    // Reset while a request is outstanding.
    exp_q.push_back('{we: 1'b1, addr: 8'h83, wdata: 8'hA5});
    scan(IR_WRITE, 8'hA5, dummy);
    ir_in = IR_STATUS;
    #1;
    check("pre_rst_req", int'(bus_req), 1);
    check("pre_rst_tdo", int'(tdo), 1);
    check("pre_rst_ir_out", int'(ir_out), 8'h01);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_req", int'(bus_req), 0);
    check("mid_rst_tdo", int'(tdo), 0);
    check("mid_rst_ir_out", int'(ir_out), 0);
    @(negedge tck);
    reset_n = 1'b1;
    @(negedge tck);
    scan(IR_STATUS, 8'h00, dout);
    check("post_rst_status", int'(dout), 8'h00);
    check("post_rst_addr", int'(bus_addr), 8'h00);

    // Unrecognised instruction: strobes must have no effect.
    scan(IR_SET, 8'h01, dummy);
    reqs_before = total_reqs;
    scan(8'h01, 8'h00, dout);
    repeat (4) @(negedge tck);
    check("unk_dout", int'(dout), 0);
    check("unk_req_count", total_reqs - reqs_before, 0);
    check("unk_addr", int'(bus_addr), 8'h01);
    ir_in = IR_READ;
    #1;
    check("unk_sr_hold", int'(tdo), 1);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
